// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative MULT/MULTU/DIV/DIVU unit holding results in HI/LO registers.
// Define ALU_MULDIV_EARLY_TERM_EN to end multiplies once the remaining multiplier bits are zero.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t st;
  logic [CW-1:0] cnt;
  logic is_div, neg, rneg, a_neg, b_neg, early, last;
  logic [2*WIDTH-1:0] prod, mcand, prod_nx, pfix;
  logic [WIDTH-1:0] mr, dvs, rem, quo, amag, bmag;
  logic [WIDTH:0] r_sh, diff;
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign amag = a_neg ? -a : a;
  assign bmag = b_neg ? -b : b;
  assign prod_nx = prod + (mr[0] ? mcand : '0);
  // partial remainder is always below twice the divisor, so bit WIDTH of diff is the borrow
  assign r_sh = {rem, quo[WIDTH-1]};
  assign diff = r_sh - {1'b0, dvs};
`ifdef ALU_MULDIV_EARLY_TERM_EN
  assign early = ~is_div & ~|mr[WIDTH-1:1];
`else
  assign early = 1'b0;
`endif
  assign last = early | (cnt == CW'(WIDTH - 1));
  assign pfix = neg ? -prod : prod;
  assign busy = st != IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st     <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg    <= 1'b0;
      rneg   <= 1'b0;
      prod   <= '0;
      mcand  <= '0;
      mr     <= '0;
      dvs    <= '0;
      rem    <= '0;
      quo    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start && !kill) begin
          is_div <= op[1];
          cnt    <= '0;
          prod   <= '0;
          mcand  <= {{WIDTH{1'b0}}, amag};
          mr     <= bmag;
          dvs    <= bmag;
          // divide by zero skips iteration: hi gets the raw dividend, lo all ones
          if (op[1] && b == '0) begin
            rem  <= a;
            quo  <= '1;
            neg  <= 1'b0;
            rneg <= 1'b0;
            st   <= FIX;
          end else begin
            rem  <= '0;
            quo  <= amag;
            neg  <= a_neg ^ b_neg;
            rneg <= a_neg;
            st   <= CALC;
          end
        end
        CALC: if (kill) st <= IDLE;
        else begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            rem <= diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          end else begin
            prod  <= prod_nx;
            mcand <= mcand << 1;
            mr    <= mr >> 1;
          end
          st <= last ? FIX : CALC;
        end
        FIX: begin
          if (!kill) begin
            hi   <= is_div ? (rneg ? -rem : rem) : pfix[2*WIDTH-1:WIDTH];
            lo   <= is_div ? (neg ? -quo : quo) : pfix[WIDTH-1:0];
            done <= 1'b1;
          end
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed checks of timing, results, kill and reset for alu_muldiv.
module tb_alu_muldiv;
  logic clk = 0, reset_n = 0, start = 0, kill = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, done;
  logic [31:0] hi, lo;
  int checks = 0, fails = 0;
`ifdef ALU_MULDIV_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  always #5 clk = ~clk;
  alu_muldiv #(.WIDTH(32)) dut (.clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .kill(kill), .busy(busy), .done(done), .hi(hi), .lo(lo));

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk); start = 1; op = o; a = x; b = y;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_done(input int c0, output int cyc, output bit bok);
    cyc = c0; bok = 1;
    while (!done && cyc < 100) begin
      if (!busy) bok = 0;
      @(negedge clk); cyc++;
    end
    if (busy) bok = 0;
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int cyc, output bit bok);
    issue(o, x, y);
    wait_done(1, cyc, bok);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", lo); end
    reset_n = 1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_mult;
    int c; bit bok;
    run(2'b00, 32'hFFFFFFFD, 32'd5, c, bok);
    checks++; if (c !== (ET ? 5 : 34)) begin fails++; $display("FAIL mult_cycle got %0d want %0d", c, ET ? 5 : 34); end
    checks++; if (bok !== 1'b1) begin fails++; $display("FAIL mult_busy got %b want 1", bok); end
    checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFF1) begin fails++; $display("FAIL mult_lo got %h want fffffff1", lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL done_pulse got %b want 0", done); end
    checks++; if (lo !== 32'hFFFFFFF1) begin fails++; $display("FAIL lo_hold got %h want fffffff1", lo); end
  endtask

  task automatic test_multu;
    int c; bit bok;
    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, c, bok);
    checks++; if (c !== 34) begin fails++; $display("FAIL multu_cycle got %0d want 34", c); end
    checks++; if (hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin fails++; $display("FAIL multu_lo got %h want 00000001", lo); end
    run(2'b01, 32'd7, 32'd3, c, bok);
    checks++; if (c !== (ET ? 4 : 34)) begin fails++; $display("FAIL multu_small_cycle got %0d want %0d", c, ET ? 4 : 34); end
    checks++; if (hi !== 32'd0) begin fails++; $display("FAIL multu_small_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd21) begin fails++; $display("FAIL multu_small_lo got %h want 15", lo); end
  endtask

  task automatic test_div;
    int c; bit bok;
    run(2'b10, 32'hFFFFFFF9, 32'd2, c, bok);
    checks++; if (c !== 34) begin fails++; $display("FAIL div_cycle got %0d want 34", c); end
    checks++; if (bok !== 1'b1) begin fails++; $display("FAIL div_busy got %b want 1", bok); end
    checks++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_hi got %h want ffffffff", hi); end
    run(2'b10, 32'd7, 32'hFFFFFFFE, c, bok);
    checks++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_negb_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'd1) begin fails++; $display("FAIL div_negb_hi got %h want 1", hi); end
    run(2'b10, 32'h80000000, 32'hFFFFFFFF, c, bok);
    checks++; if (lo !== 32'h80000000) begin fails++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
    checks++; if (hi !== 32'd0) begin fails++; $display("FAIL div_ovf_hi got %h want 0", hi); end
    run(2'b11, 32'd100, 32'd7, c, bok);
    checks++; if (lo !== 32'd14) begin fails++; $display("FAIL divu_lo got %h want e", lo); end
    checks++; if (hi !== 32'd2) begin fails++; $display("FAIL divu_hi got %h want 2", hi); end
  endtask

  task automatic test_div_zero;
    int c; bit bok;
    run(2'b11, 32'h12345678, 32'd0, c, bok);
    checks++; if (c !== 2) begin fails++; $display("FAIL dz_cycle got %0d want 2", c); end
    checks++; if (hi !== 32'h12345678) begin fails++; $display("FAIL dz_hi got %h want 12345678", hi); end
    checks++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL dz_lo got %h want ffffffff", lo); end
    run(2'b10, 32'hFFFFFFF9, 32'd0, c, bok);
    checks++; if (hi !== 32'hFFFFFFF9) begin fails++; $display("FAIL dz_signed_hi got %h want fffffff9", hi); end
    checks++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL dz_signed_lo got %h want ffffffff", lo); end
  endtask

  task automatic test_back_to_back;
    int c; bit bok;
    int rp = ET ? 2 : 5;
    issue(2'b01, 32'd6, 32'd7);
    repeat (rp - 1) @(negedge clk);
    start = 1; op = 2'b11; a = 32'd9; b = 32'd3;
    @(negedge clk); start = 0;
    wait_done(rp + 1, c, bok);
    checks++; if (c !== (ET ? 5 : 34)) begin fails++; $display("FAIL ignore_cycle got %0d want %0d", c, ET ? 5 : 34); end
    checks++; if (lo !== 32'd42) begin fails++; $display("FAIL ignore_lo got %h want 2a", lo); end
    checks++; if (hi !== 32'd0) begin fails++; $display("FAIL ignore_hi got %h want 0", hi); end
    start = 1; op = 2'b01; a = 32'd3; b = 32'd4;
    @(negedge clk); start = 0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b want 1", busy); end
    wait_done(1, c, bok);
    checks++; if (lo !== 32'd12) begin fails++; $display("FAIL b2b_lo got %h want c", lo); end
  endtask

  task automatic test_kill;
    bit seen;
    issue(2'b10, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    kill = 1;
    @(negedge clk); kill = 0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL kill_busy got %b want 0", busy); end
    checks++; if (hi !== 32'd0) begin fails++; $display("FAIL kill_hi got %h want 0", hi); end
    seen = done;
    repeat (40) begin @(negedge clk); if (done) seen = 1; end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL kill_done got %b want 0", seen); end
    checks++; if (lo !== 32'd12) begin fails++; $display("FAIL kill_lo got %h want c", lo); end
    @(negedge clk); start = 1; kill = 1; op = 2'b01; a = 32'd5; b = 32'd5;
    @(negedge clk); start = 0; kill = 0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL kill_start_busy got %b want 0", busy); end
    issue(2'b11, 32'hDEAD, 32'd0);
    kill = 1;
    @(negedge clk); kill = 0;
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL kill_fix_done got %b want 0", done); end
    checks++; if (hi !== 32'd0) begin fails++; $display("FAIL kill_fix_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd12) begin fails++; $display("FAIL kill_fix_lo got %h want c", lo); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    issue(2'b10, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    reset_n = 0;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_done got %b want 0", done); end
    checks++; if (lo !== 32'd0) begin fails++; $display("FAIL rst_mid_lo got %h want 0", lo); end
    checks++; if (hi !== 32'd0) begin fails++; $display("FAIL rst_mid_hi got %h want 0", hi); end
    @(negedge clk); reset_n = 1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen = 1; end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_mid_resume got %b want 0", seen); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div_zero;
    test_back_to_back;
    test_kill;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
